// File: rtl/ntt_intt_ip_x_heep_pkg.sv
// Shared types and constants for the Kyber NTT/INTT butterfly scheduler.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package ntt_intt_ip_x_heep_pkg;

   localparam int NTT_N      = 256;
   localparam int NTT_LAYERS = 7;

   // Butterfly operation requested from the datapath.
   typedef enum logic [1:0] {
      OP_CT    = 2'd0,
      OP_GS    = 2'd1,
      OP_SCALE = 2'd2
   } op_e;

   // Scheduler FSM states.
   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_ISSUE = 2'd1,
      ST_DRAIN = 2'd2,
      ST_DONE  = 2'd3
   } sched_state_e;

endpackage

// File: rtl/ntt_intt_addr_gen.sv
// Maps (mode, layer, butterfly index, scale pass) to the coefficient pair, twiddle index and op.
// Latency: purely combinational, 0 cycles.
// Backpressure: none; outputs follow the inputs.
//
// Ports:
//   mode_i     0=NTT (Cooley-Tukey), 1=INTT (Gentleman-Sande)
//   layer_i    layer number s, 0..6
//   j_i        butterfly index within the layer, 0..127
//   scale_i    1 during the INTT final scaling pass
//   addr_a_o / addr_b_o / zeta_idx_o / op_o   butterfly tuple
module ntt_intt_addr_gen
   import ntt_intt_ip_x_heep_pkg::*;
(
   input  logic       mode_i,
   input  logic [2:0] layer_i,
   input  logic [6:0] j_i,
   input  logic       scale_i,
   output logic [7:0] addr_a_o,
   output logic [7:0] addr_b_o,
   output logic [6:0] zeta_idx_o,
   output logic [1:0] op_o
);

   logic [2:0] sh;       // log2 of the butterfly span
   logic [3:0] grp_sh;   // sh+1, kept 4 bits wide so sh=7 does not wrap
   logic [7:0] len;
   logic [6:0] grp;
   logic [6:0] off;
   logic [7:0] addr_a;
   op_e        op;

   always_comb begin
      // NTT spans shrink 128..2 as layers advance, INTT spans grow 2..128.
      sh     = mode_i ? (layer_i + 3'd1) : (3'd7 - layer_i);
      grp_sh = {1'b0, sh} + 4'd1;
      len    = 8'd1 << sh;
      grp    = j_i >> sh;
      off    = j_i & 7'(len - 8'd1);
      // Each group occupies 2*len consecutive coefficients.
      addr_a = ({1'b0, grp} << grp_sh) | {1'b0, off};

      addr_a_o = addr_a;
      addr_b_o = addr_a + len;
      if (mode_i) begin
         // INTT walks the twiddle table backwards from the top of each level.
         zeta_idx_o = 7'((9'd256 >> sh) - 9'd1 - {2'b00, grp});
         op         = OP_GS;
      end else begin
         zeta_idx_o = 7'((8'd128 >> sh) + {1'b0, grp});
         op         = OP_CT;
      end

      // Scaling pass touches adjacent coefficient pairs, no twiddle needed.
      if (scale_i) begin
         addr_a_o   = {j_i, 1'b0};
         addr_b_o   = {j_i, 1'b1};
         zeta_idx_o = 7'd0;
         op         = OP_SCALE;
      end

      op_o = op;
   end

endmodule

// File: rtl/ntt_intt_sched.sv
// Butterfly scheduler: walks 7 NTT/INTT layers (+ INTT scale pass) over 256 coefficients.
// Latency: first tuple valid 1 cycle after start_i; one tuple per accepted handshake.
// Backpressure: valid/ready on the tuple port, tuple held while !ready; issue stalls at MAX_OUTSTANDING.
//
// Ports:
//   clk_i, rst_i                 clock, synchronous active-high reset
//   start_i, mode_i              start pulse (IDLE only) and mode (0=NTT, 1=INTT)
//   busy_o, done_o, err_o        status: issuing/draining, 1-cycle completion, sticky write-back error
//   bf_valid_o, bf_ready_i       tuple handshake
//   addr_a_o, addr_b_o, zeta_idx_o, op_o   butterfly tuple (zero while not valid)
//   wb_done_i                    one butterfly result written back
module ntt_intt_sched
   import ntt_intt_ip_x_heep_pkg::*;
#(
   parameter int N               = 256,
   parameter int MAX_OUTSTANDING = 8
)
(
   input  logic       clk_i,
   input  logic       rst_i,
   input  logic       start_i,
   input  logic       mode_i,
   output logic       busy_o,
   output logic       done_o,
   output logic       err_o,
   output logic       bf_valid_o,
   input  logic       bf_ready_i,
   output logic [7:0] addr_a_o,
   output logic [7:0] addr_b_o,
   output logic [6:0] zeta_idx_o,
   output logic [1:0] op_o,
   input  logic       wb_done_i
);

   localparam int               CNT_W      = $clog2(MAX_OUTSTANDING + 1);
   localparam logic [CNT_W-1:0] CNT_MAX    = CNT_W'(MAX_OUTSTANDING);
   localparam logic [CNT_W-1:0] CNT_ONE    = CNT_W'(1);
   localparam logic [6:0]       J_LAST     = 7'(N / 2 - 1);
   localparam logic [2:0]       LAYER_LAST = 3'(NTT_LAYERS - 1);

   sched_state_e     state_q, state_d;
   logic             mode_q, mode_d;
   logic [2:0]       layer_q, layer_d;
   logic             scale_q, scale_d;
   logic [6:0]       j_q, j_d;
   logic [CNT_W-1:0] outst_q, outst_d;
   logic             err_q, err_d;

   logic       bf_valid;
   logic       fire;
   logic [7:0] gen_addr_a;
   logic [7:0] gen_addr_b;
   logic [6:0] gen_zeta;
   logic [1:0] gen_op;

   ntt_intt_addr_gen u_addr_gen (
      .mode_i     (mode_q),
      .layer_i    (layer_q),
      .j_i        (j_q),
      .scale_i    (scale_q),
      .addr_a_o   (gen_addr_a),
      .addr_b_o   (gen_addr_b),
      .zeta_idx_o (gen_zeta),
      .op_o       (gen_op)
   );

   assign bf_valid = (state_q == ST_ISSUE) && (outst_q < CNT_MAX);
   assign fire     = bf_valid & bf_ready_i;

   // Tuple is decoded from registered state only, so it cannot change
   // while the datapath holds ready low.
   assign bf_valid_o = bf_valid;
   assign addr_a_o   = bf_valid ? gen_addr_a : 8'd0;
   assign addr_b_o   = bf_valid ? gen_addr_b : 8'd0;
   assign zeta_idx_o = bf_valid ? gen_zeta   : 7'd0;
   assign op_o       = bf_valid ? gen_op     : 2'd0;
   assign busy_o     = (state_q == ST_ISSUE) || (state_q == ST_DRAIN);
   assign done_o     = (state_q == ST_DONE);
   assign err_o      = err_q;

   always_comb begin
      state_d = state_q;
      mode_d  = mode_q;
      layer_d = layer_q;
      scale_d = scale_q;
      j_d     = j_q;
      outst_d = outst_q;
      err_d   = err_q;

      // Outstanding butterflies; a write-back with nothing in flight is
      // flagged rather than wrapping the counter.
      unique case ({fire, wb_done_i})
         2'b10: outst_d = outst_q + CNT_ONE;
         2'b01: begin
            if (outst_q == '0) err_d = 1'b1;
            else               outst_d = outst_q - CNT_ONE;
         end
         2'b11: begin
            if (outst_q == '0) err_d = 1'b1;
         end
         default: ;
      endcase

      unique case (state_q)
         ST_IDLE: begin
            if (start_i) begin
               mode_d  = mode_i;
               layer_d = 3'd0;
               scale_d = 1'b0;
               j_d     = 7'd0;
               err_d   = 1'b0;
               state_d = ST_ISSUE;
            end
         end
         ST_ISSUE: begin
            if (fire) begin
               if (j_q == J_LAST) begin
                  j_d     = 7'd0;
                  state_d = ST_DRAIN;
               end else begin
                  j_d = j_q + 7'd1;
               end
            end
         end
         ST_DRAIN: begin
            // Wait for every result of this layer to land before the next
            // layer reads any of them.
            if (outst_q == '0) begin
               if (!scale_q && (layer_q < LAYER_LAST)) begin
                  layer_d = layer_q + 3'd1;
                  state_d = ST_ISSUE;
               end else if (!scale_q && mode_q) begin
                  scale_d = 1'b1;
                  state_d = ST_ISSUE;
               end else begin
                  state_d = ST_DONE;
               end
            end
         end
         ST_DONE: begin
            state_d = ST_IDLE;
         end
         default: state_d = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         state_q <= ST_IDLE;
         mode_q  <= 1'b0;
         layer_q <= 3'd0;
         scale_q <= 1'b0;
         j_q     <= 7'd0;
         outst_q <= '0;
         err_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         mode_q  <= mode_d;
         layer_q <= layer_d;
         scale_q <= scale_d;
         j_q     <= j_d;
         outst_q <= outst_d;
         err_q   <= err_d;
      end
   end

endmodule

// File: tb/tb_ntt_intt_sched.sv
// Randomized scoreboard bench for ntt_intt_sched.
module tb_ntt_intt_sched;

   logic       clk_i = 1'b0;
   logic       rst_i;
   logic       start_i;
   logic       mode_i;
   logic       busy_o;
   logic       done_o;
   logic       err_o;
   logic       bf_valid_o;
   logic       bf_ready_i;
   logic [7:0] addr_a_o;
   logic [7:0] addr_b_o;
   logic [6:0] zeta_idx_o;
   logic [1:0] op_o;
   logic       wb_done_i;

   always #5 clk_i = ~clk_i;

   ntt_intt_sched #(.N(256), .MAX_OUTSTANDING(8)) dut (
      .clk_i      (clk_i),
      .rst_i      (rst_i),
      .start_i    (start_i),
      .mode_i     (mode_i),
      .busy_o     (busy_o),
      .done_o     (done_o),
      .err_o      (err_o),
      .bf_valid_o (bf_valid_o),
      .bf_ready_i (bf_ready_i),
      .addr_a_o   (addr_a_o),
      .addr_b_o   (addr_b_o),
      .zeta_idx_o (zeta_idx_o),
      .op_o       (op_o),
      .wb_done_i  (wb_done_i)
   );

   int          n_checks = 0;
   int          n_fail = 0;
   int          cyc = 0;
   logic [24:0] exp_q[$];
   int          wb_q[$];
   int          model_out = 0;
   int          last_zero_cyc = -100;
   int          fire_cnt = 0;
   int          done_cnt = 0;
   int          exp_total = 0;
   int          rdy_pct = 100;
   int          wb_delay = 3;
   int          long_wb_at = -1;
   bit          mon_en = 0;
   bit          rdy_auto = 0;
   bit          wb_auto = 0;
   bit          in_drain = 0;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
      n_checks++;
      if (act !== req) begin
         n_fail++;
         $display("FAIL %s: actual=%0h required=%0h (cycle %0d)", name, act, req, cyc);
      end
   endtask

   task automatic push_tuple(input int a, input int b, input int z, input int op);
      exp_q.push_back({8'(a), 8'(b), 7'(z), 2'(op)});
   endtask

   // Textbook Kyber loops: CT walks zetas upward with shrinking spans, GS walks
   // them downward with growing spans, then INTT scales adjacent pairs.
   task automatic load_model(input bit intt);
      int k;
      if (!intt) begin
         k = 1;
         for (int len = 128; len >= 2; len = len / 2)
            for (int st = 0; st < 256; st = st + 2 * len) begin
               for (int j = st; j < st + len; j++) push_tuple(j, j + len, k, 0);
               k++;
            end
      end else begin
         k = 127;
         for (int len = 2; len <= 128; len = len * 2)
            for (int st = 0; st < 256; st = st + 2 * len) begin
               for (int j = st; j < st + len; j++) push_tuple(j, j + len, k, 1);
               k--;
            end
         for (int j = 0; j < 128; j++) push_tuple(2 * j, 2 * j + 1, 0, 2);
      end
   endtask

   task automatic dec_model();
      model_out--;
      if (model_out == 0) last_zero_cyc = cyc;
   endtask

   task automatic tick();
      @(posedge clk_i);
      #3;
   endtask

   // Ready and write-back driver (datapath model).
   initial begin
      forever begin
         @(posedge clk_i);
         cyc++;
         #1;
         if (rdy_auto) bf_ready_i = ($urandom_range(0, 99) < rdy_pct);
         if (wb_auto) begin
            if (wb_q.size() > 0 && wb_q[0] <= cyc) begin
               void'(wb_q.pop_front());
               wb_done_i = 1'b1;
               dec_model();
            end else begin
               wb_done_i = 1'b0;
            end
         end
      end
   end

   // Monitor: compares every accepted tuple against the scoreboard and
   // watches layer boundaries for issue-free drains.
   initial begin
      logic [24:0] act;
      forever begin
         @(negedge clk_i);
         if (mon_en) begin
            act = {addr_a_o, addr_b_o, zeta_idx_o, op_o};
            if (!bf_valid_o) check("tuple_zero_when_invalid", 64'(act), 64'd0);
            if (model_out >= 8) check("cap_valid_low", 64'(bf_valid_o), 64'd0);
            if (in_drain) begin
               if (model_out == 0 && cyc == last_zero_cyc + 2) begin
                  check("drain_exit", 64'({bf_valid_o, done_o}),
                        (fire_cnt == exp_total) ? 64'd1 : 64'd2);
                  in_drain = 0;
               end else begin
                  check("drain_no_issue", 64'({bf_valid_o, done_o}), 64'd0);
               end
            end
            if (done_o) done_cnt++;
            if (bf_valid_o && bf_ready_i) begin
               fire_cnt++;
               if (exp_q.size() == 0) begin
                  n_checks++;
                  n_fail++;
                  $display("FAIL unexpected_fire: actual=%0h required=none", act);
               end else begin
                  check("tuple", 64'(act), 64'(exp_q.pop_front()));
               end
               wb_q.push_back(cyc + ((fire_cnt == long_wb_at) ? 20 : wb_delay));
               model_out++;
               if (fire_cnt % 128 == 0) begin
                  in_drain = 1;
                  last_zero_cyc = -100;
               end
            end
         end
      end
   end

   task automatic start_run(input bit intt, input int pct, input int dly);
      exp_q.delete();
      load_model(intt);
      exp_total = exp_q.size();
      fire_cnt  = 0;
      done_cnt  = 0;
      rdy_pct   = pct;
      wb_delay  = dly;
      in_drain  = 0;
      tick();
      mode_i  = intt;
      start_i = 1'b1;
      tick();
      start_i = 1'b0;
      mode_i  = ~intt;
      @(negedge clk_i);
      check("start_latency_valid_busy_err", 64'({bf_valid_o, busy_o, err_o}), 64'd6);
   endtask

   task automatic wait_fires(input int n);
      int k = 0;
      while (fire_cnt < n && k < 20000) begin
         tick();
         k++;
      end
      n_checks++;
      if (fire_cnt < n) begin
         n_fail++;
         $display("FAIL wait_fires_timeout: actual=%0d required=%0d", fire_cnt, n);
      end
   endtask

   task automatic finish_run();
      int k = 0;
      while (done_cnt < 1 && k < 30000) begin
         tick();
         k++;
      end
      n_checks++;
      if (done_cnt < 1) begin
         n_fail++;
         $display("FAIL done_timeout: actual=%0d required=1 done pulse", done_cnt);
      end
      repeat (3) tick();
      check("fire_count", 64'(fire_cnt), 64'(exp_total));
      check("scoreboard_empty", 64'(exp_q.size()), 64'd0);
      check("done_pulses", 64'(done_cnt), 64'd1);
      check("idle_after_busy_done_valid_err", 64'({busy_o, done_o, bf_valid_o, err_o}), 64'd0);
   endtask

   initial begin
      logic [24:0] held;
      rst_i = 1'b1;
      start_i = 1'b0;
      mode_i = 1'b0;
      bf_ready_i = 1'b0;
      wb_done_i = 1'b0;
      repeat (3) tick();
      @(negedge clk_i);
      check("reset_state", 64'({busy_o, done_o, err_o, bf_valid_o,
                                addr_a_o, addr_b_o, zeta_idx_o, op_o}), 64'd0);
      tick();
      rst_i    = 1'b0;
      mon_en   = 1;
      rdy_auto = 1;
      wb_auto  = 1;

      // NTT, always ready, start pulse mid-run must be ignored
      start_run(1'b0, 100, 3);
      wait_fires(400);
      start_i = 1'b1;
      mode_i  = 1'b1;
      tick();
      start_i = 1'b0;
      finish_run();

      // INTT with random ready and write-back delay, ignored start mid-run
      start_run(1'b1, 70, int'($urandom_range(1, 10)));
      wait_fires(500);
      start_i = 1'b1;
      mode_i  = 1'b0;
      tick();
      start_i = 1'b0;
      finish_run();

      // Backpressure: ready low for 5 cycles mid-layer, accept on the 6th
      start_run(1'b0, 100, 3);
      wait_fires(60);
      rdy_auto   = 0;
      bf_ready_i = 1'b0;
      @(negedge clk_i);
      held = {addr_a_o, addr_b_o, zeta_idx_o, op_o};
      check("bp_valid_held", 64'(bf_valid_o), 64'd1);
      repeat (4) begin
         tick();
         @(negedge clk_i);
         check("bp_valid_held", 64'(bf_valid_o), 64'd1);
         check("bp_tuple_stable", 64'({addr_a_o, addr_b_o, zeta_idx_o, op_o}), 64'(held));
      end
      tick();
      bf_ready_i = 1'b1;
      @(negedge clk_i);
      check("bp_fire_6th", 64'({bf_valid_o, addr_a_o, addr_b_o, zeta_idx_o, op_o}),
            64'({1'b1, held}));
      rdy_auto = 1;
      finish_run();

      // Write-back in IDLE sets sticky err until the next start
      wb_auto   = 0;
      wb_done_i = 1'b1;
      tick();
      wb_done_i = 1'b0;
      @(negedge clk_i);
      check("err_set_idle_wb", 64'(err_o), 64'd1);
      repeat (3) tick();
      @(negedge clk_i);
      check("err_sticky", 64'(err_o), 64'd1);

      // Outstanding cap with write-backs withheld (start also clears err)
      start_run(1'b0, 100, 3);
      repeat (20) tick();
      check("cap_fires", 64'(fire_cnt), 64'd8);
      @(negedge clk_i);
      check("cap_valid_low", 64'(bf_valid_o), 64'd0);
      tick();
      wb_done_i = 1'b1;
      void'(wb_q.pop_front());
      dec_model();
      tick();
      wb_done_i = 1'b0;
      repeat (10) tick();
      check("cap_one_more_fire", 64'(fire_cnt), 64'd9);
      wb_auto = 1;
      finish_run();

      // Slow write-back of the last layer-0 butterfly stretches the drain
      long_wb_at = 128;
      start_run(1'b0, 100, 3);
      finish_run();
      long_wb_at = -1;

      // Reset mid-run with a write-back in the same cycle, then restart
      start_run(1'b1, 100, 3);
      wait_fires(300);
      mon_en    = 0;
      wb_auto   = 0;
      rst_i     = 1'b1;
      wb_done_i = 1'b1;
      tick();
      rst_i     = 1'b0;
      wb_done_i = 1'b0;
      exp_q.delete();
      wb_q.delete();
      model_out = 0;
      in_drain  = 0;
      fire_cnt  = 0;
      done_cnt  = 0;
      @(negedge clk_i);
      check("reset_mid_run", 64'({busy_o, done_o, err_o, bf_valid_o,
                                  addr_a_o, addr_b_o, zeta_idx_o, op_o}), 64'd0);
      mon_en  = 1;
      wb_auto = 1;
      start_run(1'b0, 60, 5);
      finish_run();

      // A couple of fully random runs
      for (int r = 0; r < 2; r++) begin
         start_run(1'($urandom_range(0, 1)), int'($urandom_range(40, 100)),
                   int'($urandom_range(1, 12)));
         finish_run();
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule

// File: doc/ntt_intt_sched.md
Name: ntt_intt_sched

Overview:
Butterfly scheduler for the Kyber NTT/INTT datapath inside ntt_intt_ip_top. It takes a start/mode command from the accelerator register file and walks the 7 Cooley-Tukey (NTT) or Gentleman-Sande (INTT) layers over 256 coefficients, issuing one (addr_a, addr_b, zeta index, op) tuple per handshake. For INTT it adds a final scaling pass. It tracks outstanding butterflies, drains the pipeline between layers to avoid read-after-write hazards, and pulses done_o, which feeds the interrupt line.

Parameters:
N, 256, coefficient count (fixed Kyber; LOG_N=8 derived)
MAX_OUTSTANDING, 8, maximum butterflies issued but not yet written back
CNT_W, $clog2(MAX_OUTSTANDING+1), width of the outstanding counter (derived, localparam)

Ports:
clk_i  in  1  clock
rst_i  in  1  synchronous reset, active-high
start_i  in  1  start command pulse; sampled only in IDLE
mode_i  in  1  0=NTT, 1=INTT; latched with start_i
busy_o  out  1  high in ISSUE and DRAIN
done_o  out  1  one-cycle completion pulse
err_o  out  1  sticky flag: wb_done_i received with zero outstanding; cleared by start_i or rst_i
bf_valid_o  out  1  issue tuple valid
bf_ready_i  in  1  datapath accepts tuple
addr_a_o  out  8  first coefficient address
addr_b_o  out  8  second coefficient address
zeta_idx_o  out  7  twiddle ROM index
op_o  out  2  0=CT, 1=GS, 2=SCALE
wb_done_i  in  1  one butterfly result written back

Behaviour:
- Reset: state=IDLE, all outputs 0, outstanding=0, layer=0, j=0, err_o=0.
- FSM states: IDLE, ISSUE, DRAIN, DONE.
- IDLE + start_i: latch mode, layer s=0, j=0, clear err_o, go to ISSUE. bf_valid_o is high on the next cycle (1-cycle start latency). start_i in any other state is ignored.
- Layer length:
  - NTT: len = 128>>s.
  - INTT: len = 2<<s.
  - Let sh = log2(len), group = j>>sh, off = j & (len-1).
- Address and zeta per butterfly j (0..127):
  - addr_a = (group<<(sh+1)) | off; addr_b = addr_a + len.
  - NTT: zeta = (128>>sh) + group, op = CT.
  - INTT: zeta = (256>>sh) - 1 - group, op = GS.
- INTT scale pass (after layer 6): j = 0..127, addr_a = 2j, addr_b = 2j+1, zeta = 0, op = SCALE.
- Handshake: fire = bf_valid_o & bf_ready_i.
  - bf_valid_o = (state==ISSUE) & (outstanding < MAX_OUTSTANDING).
  - Tuple outputs are registered and held stable while valid & !ready.
  - Tuple outputs are 0 when bf_valid_o is low.
- Outstanding counter: +1 on fire, -1 on wb_done_i. Both in the same cycle: unchanged. wb_done_i at 0: counter stays 0 and err_o is set.
- Fire with j=127: go to DRAIN; j resets to 0.
- DRAIN with registered outstanding==0, next cycle:
  - to ISSUE with s+1 if more layers remain (NTT: s<6; INTT: s<6, or s==6 moves into the scale pass);
  - otherwise to DONE.
  - No issue ever crosses a layer boundary with results pending.
- DONE: done_o=1 for exactly one cycle, then IDLE.
- Issue counts: NTT = 896 issues; INTT = 1024 issues (7 drains + the scale pass drain).
- rst_i mid-operation: next cycle returns to reset state; in-flight wb_done_i pulses are ignored and do not set err_o.

Decomposition:
- ntt_intt_ip_x_heep_pkg gets: op_e enum (OP_CT, OP_GS, OP_SCALE), sched_state_e, NTT_N=256, NTT_LAYERS=7.
- One sub-module, ntt_intt_addr_gen: purely combinational mapping (mode, s, j, scale) -> (addr_a, addr_b, zeta, op). The FSM, counters and handshake stay in ntt_intt_sched.

Test Plan:
1. NTT, ready=1, wb 3 cycles after each fire:
   - first tuple (0,128,1,CT);
   - issue #128: (0,64,2,CT);
   - last issue: (253,255,127,CT);
   - exactly 896 fires, single done_o pulse, busy_o low after.
2. INTT: first tuple (0,2,127,GS); first layer-6 tuple (0,128,1,GS); scale tuples (0,1,0,SCALE) ... (254,255,0,SCALE); 1024 fires total.
3. Backpressure: ready low for 5 cycles mid-layer -> bf_valid_o stays 1, tuple unchanged, outstanding unchanged; fire on the 6th cycle.
4. Cap: wb_done_i tied 0 -> exactly 8 fires, then bf_valid_o=0; a single wb pulse -> exactly one more fire.
5. Layer drain: delay wb by 20 cycles at the end of layer 0 -> no valid during DRAIN; first layer-1 valid exactly 1 cycle after outstanding reaches 0.
6. Robustness:
   - rst_i asserted at issue #300 -> outputs 0 and state IDLE next cycle, restart works;
   - start_i while busy -> ignored;
   - wb_done_i in IDLE -> err_o=1 until the next start_i.
